// File: rtl/sc_pnode_scheduler.sv
// sc_pnode_scheduler: runs one shared combinational Pnode over a frame of
// LLR pairs, two passes per pair (raw signs, then psum-steered signs).
module sc_pnode_scheduler #(
    parameter int NPAIR = 4,
    parameter int CW    = $clog2(NPAIR) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NPAIR-1:0]   sign_c,
    input  logic [NPAIR-1:0]   sign_d,
    input  logic [NPAIR-1:0]   comp,
    input  logic [2*NPAIR-1:0] frozen_mask,
    output logic               pn_sign_c,
    output logic               pn_sign_d,
    output logic               pn_comp,
    output logic               pn_frozen1,
    output logic               pn_frozen2,
    input  logic               pn_u2i_1,
    input  logic               pn_u2i,
    output logic               busy,
    output logic               done,
    output logic [2*NPAIR-1:0] u_out,
    output logic [2*NPAIR-1:0] x_out
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        CAP_A,
        ISSUE_B,
        CAP_B,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [NPAIR-1:0]   c_q, d_q, k_q;
    logic [2*NPAIR-1:0] m_q;
    logic [CW-1:0]      idx_q;
    logic               p_q, r_q;

    logic               c_i, d_i, k_i, f1_i, f2_i;
    logic               q_i, s_i;
    logic               last_pair;
    logic [2*NPAIR-1:0] u_wr, x_wr;

    assign q_i       = p_q ^ r_q;
    assign s_i       = r_q;
    assign last_pair = (idx_q == CW'(NPAIR - 1));

    // Per-pair operand select and result merge for the current index.
    always_comb begin
        c_i  = 1'b0;
        d_i  = 1'b0;
        k_i  = 1'b0;
        f1_i = 1'b0;
        f2_i = 1'b0;
        u_wr = u_out;
        x_wr = x_out;
        for (int i = 0; i < NPAIR; i++) begin
            if (idx_q == CW'(i)) begin
                c_i  = c_q[i];
                d_i  = d_q[i];
                k_i  = k_q[i];
                f1_i = m_q[2*i];
                f2_i = m_q[2*i+1];
                u_wr[2*i]   = pn_u2i_1;
                u_wr[2*i+1] = pn_u2i;
                x_wr[2*i]   = pn_u2i_1 ^ pn_u2i;
                x_wr[2*i+1] = pn_u2i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE_A;
            ISSUE_A: state_d = CAP_A;
            CAP_A:   state_d = ISSUE_B;
            ISSUE_B: state_d = CAP_B;
            CAP_B:   state_d = last_pair ? DONE : ISSUE_A;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q        <= '0;
            d_q        <= '0;
            k_q        <= '0;
            m_q        <= '0;
            idx_q      <= '0;
            p_q        <= 1'b0;
            r_q        <= 1'b0;
            pn_sign_c  <= 1'b0;
            pn_sign_d  <= 1'b0;
            pn_comp    <= 1'b0;
            pn_frozen1 <= 1'b0;
            pn_frozen2 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            u_out      <= '0;
            x_out      <= '0;
        end else begin
            busy <= (state_d == ISSUE_A) || (state_d == CAP_A) ||
                    (state_d == ISSUE_B) || (state_d == CAP_B);
            done <= (state_d == DONE);
            unique case (state_q)
                IDLE: begin
                    pn_sign_c  <= 1'b0;
                    pn_sign_d  <= 1'b0;
                    pn_comp    <= 1'b0;
                    pn_frozen1 <= 1'b0;
                    pn_frozen2 <= 1'b0;
                    if (start) begin
                        c_q   <= sign_c;
                        d_q   <= sign_d;
                        k_q   <= comp;
                        m_q   <= frozen_mask;
                        idx_q <= '0;
                        u_out <= '0;
                        x_out <= '0;
                    end
                end
                ISSUE_A: begin
                    pn_sign_c  <= c_i;
                    pn_sign_d  <= d_i;
                    pn_comp    <= k_i;
                    pn_frozen1 <= f1_i;
                    pn_frozen2 <= f2_i;
                end
                CAP_A: begin
                    p_q <= pn_u2i_1;
                    r_q <= pn_u2i;
                end
                // Pass B: pass-A partial sums pick which LLR sign feeds each leg.
                ISSUE_B: begin
                    pn_sign_c  <= q_i ? d_i : c_i;
                    pn_sign_d  <= s_i ? d_i : c_i;
                    pn_comp    <= k_i;
                    pn_frozen1 <= f1_i;
                    pn_frozen2 <= f2_i;
                end
                CAP_B: begin
                    u_out <= u_wr;
                    x_out <= x_wr;
                    if (last_pair) begin
                        pn_sign_c  <= 1'b0;
                        pn_sign_d  <= 1'b0;
                        pn_comp    <= 1'b0;
                        pn_frozen1 <= 1'b0;
                        pn_frozen2 <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    pn_sign_c  <= 1'b0;
                    pn_sign_d  <= 1'b0;
                    pn_comp    <= 1'b0;
                    pn_frozen1 <= 1'b0;
                    pn_frozen2 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_pnode_scheduler.sv
// tb_sc_pnode_scheduler: scoreboard bench for the two-pass Pnode scheduler,
// with a behavioural combinational Pnode attached to the pn_* ports.
module tb_sc_pnode_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   sign_c = '0;
    logic [N-1:0]   sign_d = '0;
    logic [N-1:0]   comp = '0;
    logic [2*N-1:0] frozen_mask = '0;
    logic           pn_sign_c, pn_sign_d, pn_comp, pn_frozen1, pn_frozen2;
    logic           pn_u2i_1, pn_u2i;
    logic           busy, done;
    logic [2*N-1:0] u_out, x_out;
    logic [4:0]     pn_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [2*N-1:0] q_u[$];
    logic [2*N-1:0] q_x[$];
    int             q_t[$];

    sc_pnode_scheduler #(.NPAIR(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sign_c(sign_c),
        .sign_d(sign_d),
        .comp(comp),
        .frozen_mask(frozen_mask),
        .pn_sign_c(pn_sign_c),
        .pn_sign_d(pn_sign_d),
        .pn_comp(pn_comp),
        .pn_frozen1(pn_frozen1),
        .pn_frozen2(pn_frozen2),
        .pn_u2i_1(pn_u2i_1),
        .pn_u2i(pn_u2i),
        .busy(busy),
        .done(done),
        .u_out(u_out),
        .x_out(x_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Pnode: f-node sign for u2i_1, g-node sign for u2i.
    assign pn_u2i_1 = pn_frozen1 ? 1'b0 : (pn_sign_c ^ pn_sign_d);
    assign pn_u2i   = pn_frozen2 ? 1'b0 :
                      (pn_comp ? (pn_sign_c ^ pn_u2i_1) : pn_sign_d);
    assign pn_vec   = {pn_sign_c, pn_sign_d, pn_comp, pn_frozen1, pn_frozen2};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pnode(input logic sc, input logic sd, input logic cm,
                         input logic f1, input logic f2,
                         output logic u1, output logic u0);
        u1 = f1 ? 1'b0 : (sc ^ sd);
        u0 = f2 ? 1'b0 : (cm ? (sc ^ u1) : sd);
    endtask

    task automatic gold(input logic [N-1:0] c, input logic [N-1:0] d,
                        input logic [N-1:0] k, input logic [2*N-1:0] m,
                        output logic [2*N-1:0] u, output logic [2*N-1:0] x,
                        output logic [5*N-1:0] pa, output logic [5*N-1:0] pb);
        logic a1, a0, b1, b0, sc, sd;
        u = '0;
        x = '0;
        pa = '0;
        pb = '0;
        for (int i = 0; i < N; i++) begin
            pnode(c[i], d[i], k[i], m[2*i], m[2*i+1], a1, a0);
            sc = (a1 ^ a0) ? d[i] : c[i];
            sd = a0 ? d[i] : c[i];
            pnode(sc, sd, k[i], m[2*i], m[2*i+1], b1, b0);
            pa[5*i+:5] = {c[i], d[i], k[i], m[2*i], m[2*i+1]};
            pb[5*i+:5] = {sc, sd, k[i], m[2*i], m[2*i+1]};
            u[2*i]   = b1;
            u[2*i+1] = b0;
            x[2*i]   = b1 ^ b0;
            x[2*i+1] = b0;
        end
    endtask

    task automatic run_frame(input logic [N-1:0] c, input logic [N-1:0] d,
                             input logic [N-1:0] k, input logic [2*N-1:0] m,
                             input logic [2*N-1:0] eu, input logic [2*N-1:0] ex,
                             input bit scramble, input bit poke);
        logic [5*N-1:0] pa, pb;
        logic [2*N-1:0] gu, gx;
        int kc;
        gold(c, d, k, m, gu, gx, pa, pb);
        @(negedge clk);
        sign_c = c;
        sign_d = d;
        comp = k;
        frozen_mask = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        kc = cyc;
        start = 1'b0;
        q_u.push_back(eu);
        q_x.push_back(ex);
        q_t.push_back(kc + 4 * N);
        for (int j = 1; j <= 4 * N; j++) begin
            @(negedge clk);
            check("busy_in_frame", 32'(busy), 1);
            if (j == 1) check("u_out_cleared", 32'(u_out), 0);
            if (j % 4 == 2) check("pn_pass_a", 32'(pn_vec), 32'(pa[5*((j-1)/4)+:5]));
            if (j % 4 == 0) check("pn_pass_b", 32'(pn_vec), 32'(pb[5*((j-1)/4)+:5]));
            if (scramble) begin
                sign_c = N'($urandom);
                sign_d = N'($urandom);
                comp = N'($urandom);
                frozen_mask = (2*N)'($urandom);
            end
            start = poke && (j == 3);
        end
        @(negedge clk);
        check("done_state_idle_outputs", {27'd0, busy, pn_vec[3:0]}, 0);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", 32'(busy), 0);
            check("u_out_hold", 32'(u_out), 32'(eu));
            check("x_out_hold", 32'(x_out), 32'(ex));
        end
    endtask

    // Scoreboard monitor: compares each done pulse against the queued result.
    always @(negedge clk) begin
        if (done) begin
            if (q_u.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
            end else begin
                check("u_out", 32'(u_out), 32'(q_u.pop_front()));
                check("x_out", 32'(x_out), 32'(q_x.pop_front()));
                check("done_cycle", cyc, q_t.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5*N-1:0] pa, pb;
        logic [2*N-1:0] gu, gx;
        logic [N-1:0]   rc, rd, rk;
        logic [2*N-1:0] rm;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_u_out", 32'(u_out), 0);
        check("rst_x_out", 32'(x_out), 0);
        check("rst_pn", 32'(pn_vec), 0);
        rst_n = 1'b1;

        run_frame(4'b0001, 4'b0000, 4'b0001, 8'h00, 8'b0000_0011, 8'b0000_0010, 0, 0);
        run_frame(4'b0001, 4'b0000, 4'b0001, 8'h03, 8'h00, 8'h00, 0, 0);
        run_frame(4'b0001, 4'b0000, 4'b0001, 8'h00, 8'b0000_0011, 8'b0000_0010, 1, 1);

        @(negedge clk);
        sign_c = 4'b0001;
        sign_d = 4'b0000;
        comp = 4'b0001;
        frozen_mask = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_u_out", 32'(u_out), 32'h3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_u_out", 32'(u_out), 0);
        check("midrst_x_out", 32'(x_out), 0);
        check("midrst_pn", 32'(pn_vec), 0);
        rst_n = 1'b1;
        run_frame(4'b0001, 4'b0000, 4'b0001, 8'h00, 8'b0000_0011, 8'b0000_0010, 0, 0);

        for (int f = 0; f < 200; f++) begin
            rc = N'($urandom);
            rd = N'($urandom);
            rk = N'($urandom);
            rm = (2*N)'($urandom);
            gold(rc, rd, rk, rm, gu, gx, pa, pb);
            run_frame(rc, rd, rk, rm, gu, gx, 1, (f % 50) == 7);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q_u.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
